// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CNT_W  = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, try to subtract the divisor.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] partial_rem,
  input  logic          dbit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] next_rem,
  output logic          q_bit
);

  logic [VW:0]   shifted;
  logic [VW-1:0] diff;

  assign shifted = {partial_rem, dbit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the result is below the divisor, so the low VW bits are exact.
  assign diff     = shifted[VW-1:0] - divisor;
  assign next_rem = q_bit ? diff : shifted[VW-1:0];

endmodule

// File: rtl/seq_divider_8by4.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_SELFCHECK_EN adds the chk_err output that cross-checks each result.
module seq_divider_8by4
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
`ifdef DIV_SELFCHECK_EN
  output logic          chk_err,
`endif
  output logic [1:0]    fsm_state
);

  localparam int CW = $clog2(DW);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and out_valid with its data holds until accepted.

  state_t        state, state_next;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [CW-1:0] cnt;
  logic [VW-1:0] rem_q;
  logic [DW-1:0] quo_q;
  logic          dbz_q;
  logic [VW-1:0] step_rem;
  logic          step_q;

  div_step #(.VW(VW)) u_step (
    .partial_rem (rem_q),
    .dbit        (dvd_q[cnt]),
    .divisor     (dvs_q),
    .next_rem    (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            cnt   <= CW'(DW - 1);
            rem_q <= '0;
            // A zero divisor short-circuits straight to the saturated result.
            quo_q <= (divisor == '0) ? '1 : '0;
            dbz_q <= (divisor == '0);
          end
        end
        RUN: begin
          rem_q      <= step_rem;
          quo_q[cnt] <= step_q;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign fsm_state   = state;

`ifdef DIV_SELFCHECK_EN
  logic [DW+VW-1:0] prod;
  logic [DW+VW-1:0] recon;

  always_comb begin
    prod = '0;
    for (int i = 0; i < VW; i++) begin
      if (dvs_q[i]) prod = prod + ({{VW{1'b0}}, quo_q} << i);
    end
    recon   = prod + {{DW{1'b0}}, rem_q};
    chk_err = (state == DONE) && !dbz_q && (recon != {{VW{1'b0}}, dvd_q});
  end

  always @(posedge clk) begin
    if (!rst) assert (!chk_err);
  end
`endif

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Scoreboard bench for seq_divider_8by4: directed vectors plus a full operand sweep.
module tb_seq_divider_8by4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] fsm_state;
`ifdef DIV_SELFCHECK_EN
  logic       chk_err;
`endif

  int checks = 0;
  int errors = 0;

  // {div_by_zero, remainder, quotient}
  logic [12:0] exp_q[$];

  seq_divider_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
`ifdef DIV_SELFCHECK_EN
    .chk_err     (chk_err),
`endif
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expected result per output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("result", int'({div_by_zero, remainder, quotient}), int'(e));
      end
`ifdef DIV_SELFCHECK_EN
      check("chk_err", int'(chk_err), 0);
`endif
    end
  end

  // driver tasks
  task automatic push_exp(input logic [7:0] q, input logic [3:0] r, input logic z);
    exp_q.push_back({z, r, q});
  endtask

  task automatic send(input logic [7:0] a, input logic [3:0] b, input bit chk_lat, input int exp_lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (chk_lat) begin
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk); #1; n++;
      end
      check("latency", n, exp_lat);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    #3;
    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient",  int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz",       int'(div_by_zero), 0);
    check("rst_state",     int'(fsm_state), 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // directed vectors; latency counts edges after the accepting edge
    push_exp(8'd15, 4'd0, 1'b0);   send(8'd225, 4'd15, 1'b1, 8);
    push_exp(8'd28, 4'd4, 1'b0);   send(8'd200, 4'd7, 1'b1, 8);
    push_exp(8'd255, 4'd0, 1'b0);  send(8'd255, 4'd1, 1'b1, 8);
    push_exp(8'hFF, 4'd0, 1'b1);   send(8'd100, 4'd0, 1'b1, 0);
    push_exp(8'd18, 4'd2, 1'b0);   send(8'd128, 4'd7, 1'b1, 8);
    push_exp(8'd0, 4'd7, 1'b0);    send(8'd7, 4'd8, 1'b1, 8);
    cycles(1);

    // backpressure: result must hold and a new request must be ignored
    out_ready = 1'b0;
    push_exp(8'd0, 4'd0, 1'b0);
    send(8'd0, 4'd5, 1'b1, 8);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        dividend = 8'd77; divisor = 4'd2; in_valid = 1'b1;
      end
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_quotient",  int'(quotient), 0);
      check("bp_remainder", int'(remainder), 0);
      check("bp_in_ready",  int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(1);
    check("bp_release_in_ready", int'(in_ready), 1);
    cycles(10);
    check("bp_ignored_out_valid", int'(out_valid), 0);

    // reset in the middle of an operation
    send(8'd200, 4'd7, 1'b0, 0);
    cycles(3);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_quotient",  int'(quotient), 0);
    check("mid_rst_remainder", int'(remainder), 0);
    check("mid_rst_dbz",       int'(div_by_zero), 0);
    check("mid_rst_state",     int'(fsm_state), 0);
    cycles(2);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_output", seen, 0);
    push_exp(8'd3, 4'd0, 1'b0);
    send(8'd9, 4'd3, 1'b1, 8);

    // full sweep, back to back, against the arithmetic reference
    for (int b = 1; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        push_exp(8'(a / b), 4'(a % b), 1'b0);
        send(8'(a), 4'(b), 1'b0, 0);
      end
    end

    seen = 0;
    while (exp_q.size() != 0 && seen < 50) begin
      @(posedge clk); #1; seen++;
    end
    cycles(2);
    check("pending_results", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
